// File: rtl/ssd_scan_ctrl.sv
// Time-multiplexed scan controller for a 4-digit common-anode seven-segment display.
// Each digit gets a fixed slot of SCAN_DIV cycles. The first BLANK_CYCLES of every slot
// keep all anodes dark to suppress ghosting. Inputs are captured once per frame.
module ssd_scan_ctrl #(
    parameter int unsigned SCAN_DIV     = 100000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] digit1,
    input  logic [3:0] digit2,
    input  logic [3:0] digit3,
    input  logic [3:0] digit4,
    input  logic [3:0] dp_en,
    input  logic       lz_blank,
    output logic [7:0] seg_cat,
    output logic [3:0] seg_an,
    output logic       frame_tick
);

    localparam int unsigned CNT_W = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_SHOW = CNT_W'(BLANK_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [3:0][3:0]   sh_digit_q, sh_digit_d;
    logic [3:0]        sh_dp_q, sh_dp_d;
    logic              sh_lz_q, sh_lz_d;
    logic [7:0]        seg_cat_q, seg_cat_d;
    logic [3:0]        seg_an_q, seg_an_d;
    logic              frame_tick_q, frame_tick_d;
    logic [3:0]        suppress_c;
    logic              capture_c;

    // BCD to active-low {g,f,e,d,c,b,a}; non-BCD values render as a dash.
    function automatic logic [6:0] decode7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h3F;
        endcase
        return s;
    endfunction

    // Leading-zero suppression mask from the frame shadow; the rightmost digit always shows.
    always_comb begin
        suppress_c    = 4'b0000;
        suppress_c[3] = sh_lz_q && (sh_digit_q[3] == 4'd0);
        suppress_c[2] = suppress_c[3] && (sh_digit_q[2] == 4'd0);
        suppress_c[1] = suppress_c[2] && (sh_digit_q[1] == 4'd0);
    end

    // Next-state, shadow capture and next registered outputs.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        sh_digit_d   = sh_digit_q;
        sh_dp_d      = sh_dp_q;
        sh_lz_d      = sh_lz_q;
        capture_c    = 1'b0;
        seg_an_d     = 4'hF;
        seg_cat_d    = 8'hFF;
        frame_tick_d = 1'b0;

        if (!en) begin
            state_d = ST_OFF;
            idx_d   = 2'd0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_OFF: begin
                    state_d   = ST_BLANK;
                    idx_d     = 2'd0;
                    cnt_d     = '0;
                    capture_c = 1'b1;
                end
                ST_BLANK: begin
                    cnt_d = cnt_q + CNT_ONE;
                    if (cnt_q + CNT_ONE == CNT_SHOW) begin
                        state_d = ST_SHOW;
                    end
                end
                ST_SHOW: begin
                    if (cnt_q == CNT_LAST) begin
                        state_d   = ST_BLANK;
                        idx_d     = idx_q + 2'd1;
                        cnt_d     = '0;
                        capture_c = (idx_q == 2'd3);
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = ST_OFF;
                    idx_d   = 2'd0;
                    cnt_d   = '0;
                end
            endcase
        end

        // Frame boundary: latch everything the next frame will display.
        if (capture_c) begin
            sh_digit_d = {digit4, digit3, digit2, digit1};
            sh_dp_d    = dp_en;
            sh_lz_d    = lz_blank;
        end

        // Outputs follow the state/idx/cnt being loaded on this edge. Shadows never
        // change on an edge that enters SHOW, so the current shadow is the right one.
        if (state_d == ST_SHOW && !suppress_c[idx_d]) begin
            seg_an_d  = ~(4'b0001 << idx_d);
            seg_cat_d = {~sh_dp_q[idx_d], decode7(sh_digit_q[idx_d])};
        end
        frame_tick_d = (state_d == ST_SHOW) && (idx_d == 2'd3) && (cnt_d == CNT_LAST);
    end

    // State, shadow and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_OFF;
            idx_q        <= 2'd0;
            cnt_q        <= '0;
            sh_digit_q   <= '0;
            sh_dp_q      <= 4'h0;
            sh_lz_q      <= 1'b0;
            seg_cat_q    <= 8'hFF;
            seg_an_q     <= 4'hF;
            frame_tick_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            sh_digit_q   <= sh_digit_d;
            sh_dp_q      <= sh_dp_d;
            sh_lz_q      <= sh_lz_d;
            seg_cat_q    <= seg_cat_d;
            seg_an_q     <= seg_an_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign seg_cat    = seg_cat_q;
    assign seg_an     = seg_an_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Scoreboard bench for ssd_scan_ctrl with SCAN_DIV=8, BLANK_CYCLES=2.
// Stimulus pushes per-cycle expected outputs tagged with a clock-edge index;
// a monitor on the falling edge pops and compares them.
module tb_ssd_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [3:0] digit1, digit2, digit3, digit4;
    logic [3:0] dp_en;
    logic       lz_blank;
    logic [7:0] seg_cat;
    logic [3:0] seg_an;
    logic       frame_tick;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int         cyc;
        logic [3:0] an;
        logic [7:0] cat;
        logic       tick;
    } exp_t;

    exp_t sb[$];

    ssd_scan_ctrl #(.SCAN_DIV(8), .BLANK_CYCLES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .digit1    (digit1),
        .digit2    (digit2),
        .digit3    (digit3),
        .digit4    (digit4),
        .dp_en     (dp_en),
        .lz_blank  (lz_blank),
        .seg_cat   (seg_cat),
        .seg_an    (seg_an),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    // Edge index: outputs seen at a falling edge belong to the edge numbered cyc.
    always @(posedge clk) cyc++;

    task automatic push(input int c, input logic [3:0] an, input logic [7:0] cat, input logic tick);
        exp_t e;
        e.cyc  = c;
        e.an   = an;
        e.cat  = cat;
        e.tick = tick;
        sb.push_back(e);
    endtask

    task automatic push_dark(input int first, input int last);
        for (int c = first; c <= last; c++) push(c, 4'hF, 8'hFF, 1'b0);
    endtask

    // Expected outputs for ncyc cycles of a frame starting at edge base.
    task automatic push_frame(input int base, input logic [7:0] c0, input logic [7:0] c1,
                              input logic [7:0] c2, input logic [7:0] c3,
                              input logic [3:0] lit, input int ncyc);
        logic [7:0] cs [4];
        logic [3:0] one;
        cs[0] = c0; cs[1] = c1; cs[2] = c2; cs[3] = c3;
        one = 4'b0001;
        for (int i = 0; i < ncyc; i++) begin
            int slot;
            int k;
            logic [3:0] an;
            logic [7:0] cat;
            slot = i / 8;
            k    = i % 8;
            an   = 4'hF;
            cat  = 8'hFF;
            if (k >= 2 && lit[slot]) begin
                an  = ~(one << slot);
                cat = cs[slot];
            end
            push(base + i, an, cat, (i == 31));
        end
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Monitor: compare every tagged expectation against the outputs of its edge.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            checks++;
            errors++;
            $display("FAIL missed_expectation edge=%0d", sb[0].cyc);
            void'(sb.pop_front());
        end
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if ({seg_an, seg_cat, frame_tick} !== {e.an, e.cat, e.tick}) begin
                errors++;
                $display("FAIL scan edge=%0d got an=%b cat=%h tick=%b want an=%b cat=%h tick=%b",
                         cyc, seg_an, seg_cat, frame_tick, e.an, e.cat, e.tick);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        rst      = 1'b1;
        en       = 1'b0;
        digit1   = 4'd4;
        digit2   = 4'd3;
        digit3   = 4'd2;
        digit4   = 4'd1;
        dp_en    = 4'b0000;
        lz_blank = 1'b0;
        push_dark(1, 4);

        wait_cyc(2);
        rst = 1'b0;

        // Basic scan 1,2,3,4; frame starts on edge 5.
        wait_cyc(4);
        en = 1'b1;
        push_frame(5, 8'h99, 8'hB0, 8'hA4, 8'hF9, 4'hF, 32);
        wait_cyc(36);
        push_frame(37, 8'h99, 8'hB0, 8'hA4, 8'hF9, 4'hF, 32);
        wait_cyc(68);
        push_frame(69, 8'h99, 8'hB0, 8'hA4, 8'hF9, 4'hF, 32);

        // Mid-frame change in slot 2 only lands in the next frame.
        wait_cyc(88);
        digit1 = 4'd7;
        wait_cyc(100);
        push_frame(101, 8'hF8, 8'hB0, 8'hA4, 8'hF9, 4'hF, 32);

        // Leading-zero blanking with 0,0,5,0.
        wait_cyc(110);
        lz_blank = 1'b1;
        digit4 = 4'd0; digit3 = 4'd0; digit2 = 4'd5; digit1 = 4'd0;
        wait_cyc(132);
        push_frame(133, 8'hC0, 8'h92, 8'hFF, 8'hFF, 4'b0011, 32);

        // All zeros: only the rightmost digit lights.
        wait_cyc(140);
        digit2 = 4'd0;
        wait_cyc(164);
        push_frame(165, 8'hC0, 8'hFF, 8'hFF, 8'hFF, 4'b0001, 32);

        // Decimal point on digit2=3.
        wait_cyc(170);
        lz_blank = 1'b0;
        digit2 = 4'd3;
        dp_en = 4'b0010;
        wait_cyc(196);
        push_frame(197, 8'hC0, 8'h30, 8'hC0, 8'hC0, 4'hF, 32);

        // Non-BCD value shows a dash.
        wait_cyc(200);
        digit1 = 4'd12;
        wait_cyc(228);
        push_frame(229, 8'hBF, 8'h30, 8'hC0, 8'hC0, 4'hF, 32);

        // Drop en while the scan is at slot 1 cnt 5 (edge 274).
        wait_cyc(260);
        push_frame(261, 8'hBF, 8'h30, 8'hC0, 8'hC0, 4'hF, 14);
        wait_cyc(274);
        en = 1'b0;
        digit1 = 4'd9;
        push_dark(275, 279);

        // Reassert: restart at slot 0 with a fresh capture.
        wait_cyc(279);
        en = 1'b1;
        push_frame(280, 8'h90, 8'h30, 8'hC0, 8'hC0, 4'hF, 32);
        wait_cyc(311);
        push_frame(312, 8'h90, 8'h30, 8'hC0, 8'hC0, 4'hF, 5);

        // Asynchronous reset in the middle of a lit slot.
        wait_cyc(316);
        #2;
        rst = 1'b1;
        en  = 1'b0;
        #1;
        checks++;
        if ({seg_an, seg_cat, frame_tick} !== {4'hF, 8'hFF, 1'b0}) begin
            errors++;
            $display("FAIL async_reset got an=%b cat=%h tick=%b want an=1111 cat=ff tick=0",
                     seg_an, seg_cat, frame_tick);
        end
        push_dark(317, 326);
        wait_cyc(318);
        rst = 1'b0;

        wait_cyc(327);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ssd_scan_ctrl.md
# ssd_scan_ctrl

Time-multiplexing scan controller for the 4-digit common-anode seven-segment display on the board. It takes four BCD digit values and per-digit decimal-point enables from the counter datapath and schedules the single shared cathode bus across the four anodes. Each digit gets a fixed slot with a leading blanking interval to suppress ghosting. Digit values are captured once per frame so the display never tears mid-scan. It drives `seg_cat`/`seg_an` directly at top level.

## Interface
- `SCAN_DIV`, 100000: clock cycles per digit slot (1 ms at 100 MHz); legal range ≥ 2.
- `BLANK_CYCLES`, 1000: cycles at the start of each slot with all anodes off; legal range 1 ≤ BLANK_CYCLES < SCAN_DIV.

- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `en`  in  1  display enable; 0 turns the display off and parks the scanner.
- `digit1..digit4`  in  4 each  BCD values; digit1 is the rightmost digit (anode 0), digit4 is the leftmost (anode 3).
- `dp_en`  in  4  decimal-point enable; bit i maps to anode i.
- `lz_blank`  in  1  leading-zero blanking enable.
- `seg_cat`  out  8  cathodes, active-low, ordered {dp,g,f,e,d,c,b,a}.
- `seg_an`  out  4  anodes, active-low; bit i is digit i+1.
- `frame_tick`  out  1  one-cycle pulse in the last cycle of slot 3.

## Operation
- States:
  - OFF: parked, display dark.
  - BLANK: slot active, anodes off.
  - SHOW: slot active, one anode on.
- Slot index `idx` runs 0..3. Cycle counter `cnt` runs 0..SCAN_DIV-1 within each slot.
- Transitions:
  - OFF→BLANK when `en`=1. Sets idx=0, cnt=0, and captures the shadow registers.
  - BLANK→SHOW when cnt reaches BLANK_CYCLES.
  - SHOW→BLANK at cnt=SCAN_DIV-1. Sets idx=idx+1 mod 4 and cnt=0.
  - Wrap from idx 3 to idx 0 recaptures the shadow registers.
  - Any state→OFF when `en`=0. Sets idx=0, cnt=0.
- Shadow capture: `digit1..4`, `dp_en` and `lz_blank` are sampled on the edge that enters slot 0 cnt 0. All display decisions for the whole frame use the shadow values.
- Decode, for {g..a}, active-low:
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90 (8-bit with dp off).
  - Values 10–15 show a dash: only g lit, 0xBF.
- Decimal point: `seg_cat[7]` = ~shadow dp_en[idx] in SHOW.
- Leading-zero blanking (shadow lz_blank=1):
  - digit k (k=2..4) is suppressed when it and every digit above it are 0.
  - digit1 is never suppressed.
  - A suppressed slot keeps `seg_an`=1111 and `seg_cat`=FF for the full slot. Timing is unchanged.
- In OFF and BLANK: `seg_an`=1111, `seg_cat`=FF.
- In SHOW: exactly one `seg_an` bit (idx) is 0.

## Timing
- Reset values:
  - state OFF, idx 0, cnt 0, shadows 0.
  - `seg_an`=1111, `seg_cat`=FF, `frame_tick`=0.
- `rst` forces the reset values immediately, without waiting for a clock edge.
- Outputs are registered. They change on the same edge as the state/idx/cnt that selects them, with no additional pipeline delay.
- One frame is 4·SCAN_DIV cycles. `frame_tick` is high only when idx=3 and cnt=SCAN_DIV-1 with `en`=1.
- Anode i is on for cnt ∈ [BLANK_CYCLES, SCAN_DIV-1] of slot i. Every anode change is therefore separated by ≥ BLANK_CYCLES dark cycles.
- Input changes mid-frame take effect at the next frame boundary, never within the current frame.
- Deasserting `en`: the display goes dark on the next edge and `frame_tick` does not fire.
- Reasserting `en`: the scan restarts at slot 0 BLANK with a fresh capture.

## Test plan
All scenarios use SCAN_DIV=8 and BLANK_CYCLES=2.

- **Reset:** assert `rst` asynchronously mid-SHOW. Required: `seg_an`=1111 and `seg_cat`=FF before the next clk edge. These hold while `en`=0.
- **Basic scan:** `en`=1, digit4..1=1,2,3,4, dp_en=0, lz_blank=0.
  - Slot 0 cycles 2–7: `seg_an`=1110, `seg_cat`=99.
  - Slots 1/2/3: an=1101/1011/0111, cat=B0/A4/F9.
  - Cycles 0–1 of each slot are dark.
  - `frame_tick` fires every 32 cycles.
- **No tearing:** change digit1 4→7 during slot 2. Required: the remainder of the frame is unchanged, and the next frame's slot 0 shows F8.
- **Leading-zero blanking:** lz_blank=1, digit4..1=0,0,5,0.
  - Slots 0 and 1 show C0 and 92.
  - Slots 2 and 3 stay at 1111/FF.
  - With all digits 0, only slot 0 lights (C0).
- **Decimal point and non-BCD:** dp_en=0010 with digit2=3 → slot 1 `seg_cat`=30. Then digit1=12 → slot 0 `seg_cat`=BF.
- **Enable toggling:** drop `en` at slot 1 cnt 5. Required: next edge 1111/FF with no `frame_tick`. Reassert `en`: scan resumes at slot 0, dark for 2 cycles, then `seg_an`=1110.
